// File: rtl/uart_tx64.sv
// Multi-byte UART transmitter: latches a 64-bit block and sends NUM_BYTES frames back to back.
// Optional even parity bit per frame when UART_TX64_PARITY_EN is defined.
module uart_tx64 #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int NUM_BYTES    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_in,
  input  logic        start,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [2:0]  byte_idx,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX64_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;

  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BYTE  = 3'(NUM_BYTES - 1);

  // Handshake: start is a level request sampled every clk; it is taken only in
  // IDLE (busy=0). busy rises with the first start bit, done pulses as busy falls.
  logic [2:0]  state;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [63:0] shadow;
  logic        armed;
  logic [7:0]  cur_byte;

  assign cur_byte  = shadow[{byte_idx, 3'b000} +: 8];
  assign state_dbg = state;

  // armed blocks acceptance on the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= 16'd0;
      bit_idx  <= 3'd0;
      shadow   <= 64'd0;
      armed    <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_idx <= 3'd0;
    end else begin
      armed <= 1'b1;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && armed) begin
            shadow   <= data_in;
            state    <= S_START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            timer    <= BIT_RELOAD;
            byte_idx <= 3'd0;
            bit_idx  <= 3'd0;
          end
        end
        S_START: begin
          if (timer == 16'd0) begin
            state   <= S_DATA;
            tx      <= cur_byte[0];
            bit_idx <= 3'd0;
            timer   <= BIT_RELOAD;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        S_DATA: begin
          if (timer == 16'd0) begin
            timer   <= BIT_RELOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX64_PARITY_EN
              state <= S_PARITY;
              tx    <= ^cur_byte;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              tx <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
`ifdef UART_TX64_PARITY_EN
        S_PARITY: begin
          if (timer == 16'd0) begin
            state <= S_STOP;
            tx    <= 1'b1;
            timer <= BIT_RELOAD;
          end else begin
            timer <= timer - 16'd1;
          end
        end
`endif
        // NEXT_BYTE occupies the final cycle of the stop bit, so it adds no gap.
        S_STOP: begin
          if (timer == 16'd1) begin
            state <= S_NEXT;
            timer <= 16'd0;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        S_NEXT: begin
          if (byte_idx == LAST_BYTE) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            byte_idx <= 3'd0;
            tx       <= 1'b1;
            timer    <= 16'd0;
          end else begin
            state    <= S_START;
            byte_idx <= byte_idx + 3'd1;
            tx       <= 1'b0;
            timer    <= BIT_RELOAD;
          end
        end
        default: begin
          state    <= S_IDLE;
          tx       <= 1'b1;
          busy     <= 1'b0;
          byte_idx <= 3'd0;
          timer    <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx64.sv
// Directed bench for uart_tx64: 8-byte instance for block timing/order, 1-byte instance for an exact bit pattern.
module tb_uart_tx64;
  localparam int CPB = 4;
  localparam int NB  = 8;
`ifdef UART_TX64_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk, rst;
  logic [63:0] data_in, data_in2;
  logic        start, start2;
  logic        tx, busy, done, tx2, busy2, done2;
  logic [2:0]  byte_idx, state_dbg, byte_idx2, state_dbg2;

  int checks = 0;
  int errors = 0;
  logic [FB-1:0] exp_q[$];

  uart_tx64 #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .start(start), .tx(tx),
    .busy(busy), .done(done), .byte_idx(byte_idx), .state_dbg(state_dbg));

  uart_tx64 #(.CLKS_PER_BIT(CPB), .NUM_BYTES(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in2), .start(start2), .tx(tx2),
    .busy(busy2), .done(done2), .byte_idx(byte_idx2), .state_dbg(state_dbg2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check_val(name, 64'(act), 64'(exp));
  endtask

  function automatic logic [FB-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX64_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  // driver: leaves the caller #1 after the accepting edge
  task automatic issue_start(input logic [63:0] d, input bit hold, input logic [63:0] d_next);
    @(negedge clk);
    data_in = d;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = hold;
    data_in = d_next;
  endtask

  // scoreboard for one 8-byte block; entry point is #1 after the accepting edge
  task automatic check_block(input logic [63:0] d, input int dist_cyc,
                             input logic [63:0] dist_data, input bit hold_start);
    logic [FB-1:0] got;
    logic [FB-1:0] expf;
    int nbits, done_cyc, busy_bad, idx_bad, bi;
    nbits = NB * FB;
    done_cyc = -1;
    busy_bad = 0;
    idx_bad = 0;
    got = '0;
    for (int b = 0; b < NB; b++) exp_q.push_back(frame_of(d[8*b +: 8]));
    check_bit("tx_low_at_accept", tx, 1'b0);
    check_bit("busy_at_accept", busy, 1'b1);
    check_bit("no_done_at_accept", done, 1'b0);
    for (int cyc = 1; cyc <= nbits * CPB + 20; cyc++) begin
      @(posedge clk);
      #1;
      if (dist_cyc != 0 && cyc == dist_cyc) begin
        start   = 1'b1;
        data_in = dist_data;
      end else if (dist_cyc != 0 && cyc == dist_cyc + 1) begin
        start = 1'b0;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!busy) busy_bad++;
      if ((cyc % CPB) == (CPB / 2) && cyc < nbits * CPB) begin
        bi = cyc / CPB;
        got[bi % FB] = tx;
        if (byte_idx != 3'(bi / FB)) idx_bad++;
        if ((bi % FB) == FB - 1 && exp_q.size() > 0) begin
          expf = exp_q.pop_front();
          check_val("frame", 64'(got), 64'(expf));
        end
      end
    end
    check_val("done_cycle", 64'(done_cyc), 64'(nbits * CPB));
    check_val("busy_low_during_block", 64'(busy_bad), 64'd0);
    check_val("byte_idx_during_block", 64'(idx_bad), 64'd0);
    check_val("frames_missing", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check_bit("busy_at_done", busy, 1'b0);
    check_bit("tx_at_done", tx, 1'b1);
    check_val("byte_idx_at_done", 64'(byte_idx), 64'd0);
    if (!hold_start) begin
      @(posedge clk);
      #1;
      check_bit("done_one_cycle", done, 1'b0);
      check_bit("tx_idle_after_done", tx, 1'b1);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    int          dist_cyc;
    logic [63:0] dist_data;
  } vec_t;

  vec_t vecs[4];
  logic a5_bits[FB];
  int   rst_cyc;

  initial begin
    vecs[0] = '{data: 64'h0706050403020100, dist_cyc: 0, dist_data: 64'h0};
    vecs[1] = '{data: 64'hDEADBEEF01234567, dist_cyc: 0, dist_data: 64'h0};
    vecs[2] = '{data: 64'h0706050403020100, dist_cyc: CPB * (3 * FB + 2) + 1,
                dist_data: 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{data: 64'h8000000000000001, dist_cyc: 0, dist_data: 64'h0};
`ifdef UART_TX64_PARITY_EN
    a5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    a5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

    rst = 1'b1;
    start = 1'b0;
    data_in = 64'h0;
    start2 = 1'b0;
    data_in2 = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_tx", tx, 1'b1);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_val("reset_byte_idx", 64'(byte_idx), 64'd0);
    check_val("reset_state", 64'(state_dbg), 64'd0);
    check_bit("reset_tx_1b", tx2, 1'b1);
    check_bit("reset_busy_1b", busy2, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      issue_start(vecs[i].data, 1'b0, vecs[i].data);
      check_block(vecs[i].data, vecs[i].dist_cyc, vecs[i].dist_data, 1'b0);
    end

    // start held high through done: second block accepted in the done cycle
    issue_start(64'h1122334455667788, 1'b1, 64'hCAFEF00D12345678);
    check_block(64'h1122334455667788, 0, 64'h0, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_block(64'hCAFEF00D12345678, 0, 64'h0, 1'b0);

    // reset during byte 5 bit 2
    issue_start(64'h0102030405060708, 1'b0, 64'h0102030405060708);
    rst_cyc = CPB * (5 * FB + 3) + 1;
    repeat (rst_cyc) @(posedge clk);
    #1;
    check_val("byte_idx_before_rst", 64'(byte_idx), 64'd5);
    rst = 1'b1;
    #1;
    check_bit("midrst_tx", tx, 1'b1);
    check_bit("midrst_busy", busy, 1'b0);
    check_val("midrst_byte_idx", 64'(byte_idx), 64'd0);
    check_bit("midrst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    data_in = 64'h5555555555555555;
    @(posedge clk);
    rst = 1'b0;
    #1;
    check_bit("start_on_rst_release_busy", busy, 1'b0);
    check_bit("start_on_rst_release_tx", tx, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_bit("idle_after_rst_busy", busy, 1'b0);
    check_bit("idle_after_rst_done", done, 1'b0);
    issue_start(64'h0706050403020100, 1'b0, 64'h0);
    check_block(64'h0706050403020100, 0, 64'h0, 1'b0);

    // single-byte instance, byte A5
    @(negedge clk);
    data_in2 = 64'hA5;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int b = 0; b < FB; b++) begin
      repeat ((b == 0) ? 2 : CPB) @(posedge clk);
      #1;
      check_bit($sformatf("a5_bit%0d", b), tx2, a5_bits[b]);
      check_bit($sformatf("a5_busy%0d", b), busy2, 1'b1);
    end
    repeat (CPB - CPB / 2) @(posedge clk);
    #1;
    check_bit("a5_done", done2, 1'b1);
    check_bit("a5_busy_at_done", busy2, 1'b0);
    check_bit("a5_tx_at_done", tx2, 1'b1);
    @(posedge clk);
    #1;
    check_bit("a5_done_cleared", done2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx64.md
UART_TX64 -- requirements
Module: uart_tx64

Interface
REQ-001 Parameter CLKS_PER_BIT, default 2604, clk cycles per serial bit (19200 baud at 50 MHz); legal range 2..65535.
REQ-002 Parameter NUM_BYTES, default 8, bytes per block; legal range 1..8.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 data_in  input  64  block to transmit; byte k = data_in[8k+7:8k].
REQ-006 start  input  1  request to transmit one block; sampled each clk.
REQ-007 tx  output  1  serial line, idle high; registered.
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse when the last stop bit completes.
REQ-010 byte_idx  output  3  index of the byte currently on the line; 0 when idle.

Function
REQ-011 FSM states: IDLE, START_BIT, DATA_BITS, PARITY (macro only), STOP_BIT, NEXT_BYTE.
REQ-012 IDLE: start=1 with busy=0 is accepted, data_in is latched into a 64-bit shadow register, and the FSM moves to START_BIT with byte_idx=0.
REQ-013 start while busy=1 is ignored; the shadow register is not changed and the frame is not disturbed.
REQ-014 tx goes low on the first clk edge after acceptance; each bit holds exactly CLKS_PER_BIT cycles, counted by a 16-bit bit timer that reloads on every state or bit change.
REQ-015 Frame per byte: 1 start bit (0), then 8 data bits LSB first, then optional parity, then 1 stop bit (1).
REQ-016 Bytes are sent in order byte 0 to byte NUM_BYTES-1, with no idle gap between one stop bit and the next start bit.
REQ-017 NEXT_BYTE lasts 0 bit-times: it increments byte_idx and enters START_BIT. After byte NUM_BYTES-1 it enters IDLE instead.
REQ-018 Entering IDLE: done=1 and busy=0 in the same cycle, tx=1, byte_idx=0.
REQ-019 start=1 in the done cycle is accepted, giving back-to-back blocks with a minimum of 1 idle clk of tx=1.
REQ-020 Total block duration is NUM_BYTES*10*CLKS_PER_BIT cycles, or NUM_BYTES*11*CLKS_PER_BIT with parity, measured from the first tx low to done.
REQ-021 A data-bit index counter (3 bits) wraps 7 to 0 at the end of each byte and never indexes outside the shadow byte.

Reset
REQ-022 rst=1 forces IDLE immediately and asynchronously: tx=1, busy=0, done=0, byte_idx=0, bit timer=0, shadow=0.
REQ-023 rst asserted mid-frame aborts the block without a done pulse. After release, the FSM waits in IDLE for a new start.
REQ-024 start coincident with the rst release edge is ignored.

Configuration
REQ-025 Macro UART_TX64_PARITY_EN defined: a PARITY state inserts one even-parity bit (XOR of the 8 data bits) between bit 7 and the stop bit. The frame becomes 11 bits.
REQ-026 Macro UART_TX64_PARITY_EN undefined: the PARITY state and its logic are absent, and the frame is 10 bits.

Verification
REQ-027 CLKS_PER_BIT=4, data_in=64'h0706050403020100, start pulse -> tx decodes to bytes 00,01,...,07 in order, and done fires exactly 320 cycles after the first tx low.
REQ-028 data_in=64'hA5 in byte 0, others 0, NUM_BYTES=1 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, then done, with busy low the same cycle.
REQ-029 start re-pulsed with a different data_in during byte 3 -> the waveform is identical to the undisturbed run, and busy stays high.
REQ-030 start held high through done -> a second block starts 1 cycle after done with newly latched data, and no stop-bit truncation occurs.
REQ-031 rst asserted during byte 5 bit 2 -> tx=1, busy=0, byte_idx=0 within the same cycle, with no done; a following start sends a full block.
REQ-032 With UART_TX64_PARITY_EN, byte 8'h07 -> parity bit 1 and frame length 44 cycles; byte 8'h03 -> parity bit 0.
